// File: rtl/usb_uart_master_pkg.sv
// Shared definitions for the USB UART register interface: default register
// addresses, FSM state encoding and the poll-ready test.
package usb_uart_master_pkg;

    localparam logic [3:0] TX_RDY_ADDR = 4'h0;
    localparam logic [3:0] TX_DAT_ADDR = 4'h1;
    localparam logic [3:0] RX_RDY_ADDR = 4'h2;
    localparam logic [3:0] RX_DAT_ADDR = 4'h3;

    typedef enum logic [3:0] {
        StIdle,
        StTxq,
        StTxc,
        StTxw,
        StRxq,
        StRxc,
        StRxd,
        StRxl,
        StGap
    } state_e;

    function automatic logic poll_ready(input logic [7:0] status);
        return status != 8'h00;
    endfunction

endpackage

// File: rtl/usb_uart_master.sv
// Bus initiator for the USB UART registers: turns client tx/rx byte streams
// into polled register accesses, alternating tx and rx service.
module usb_uart_master
    import usb_uart_master_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4,
    parameter logic [3:0]  TX_RDY_A = TX_RDY_ADDR,
    parameter logic [3:0]  TX_DAT_A = TX_DAT_ADDR,
    parameter logic [3:0]  RX_RDY_A = RX_RDY_ADDR,
    parameter logic [3:0]  RX_DAT_A = RX_DAT_ADDR
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_rx_ready,
    output logic       o_en,
    output logic       o_wr,
    output logic [3:0] o_addr,
    output logic [7:0] o_data,
    input  logic [7:0] i_data
);

    localparam logic [7:0] GapInit = 8'(POLL_GAP);

    state_e     state_q, state_d;
    logic       tx_pending_q, tx_pending_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic       prio_rx_q, prio_rx_d;

    logic tx_accept, tx_elig, rx_elig;

    // Accepting a byte in IDLE makes tx eligible in the same cycle, giving 4-cycle throughput.
    assign tx_accept = (state_q == StIdle) && !tx_pending_q && i_tx_valid && !i_rst;
    assign tx_elig   = tx_pending_q || tx_accept;
    assign rx_elig   = !rx_valid_q;

    always_comb begin
        state_d      = state_q;
        tx_pending_d = tx_pending_q;
        tx_byte_d    = tx_byte_q;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        gap_cnt_d    = gap_cnt_q;
        prio_rx_d    = prio_rx_q;
        o_tx_ready   = 1'b0;
        o_en         = 1'b0;
        o_wr         = 1'b0;
        o_addr       = 4'h0;
        o_data       = 8'h00;

        if (rx_valid_q && i_rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (tx_accept) begin
                    o_tx_ready   = 1'b1;
                    tx_byte_d    = i_tx_data;
                    tx_pending_d = 1'b1;
                end
                if (tx_elig && (!rx_elig || !prio_rx_q)) begin
                    state_d   = StTxq;
                    prio_rx_d = 1'b1;
                end else if (rx_elig) begin
                    state_d   = StRxq;
                    prio_rx_d = 1'b0;
                end
            end
            StTxq: begin
                o_en    = 1'b1;
                o_addr  = TX_RDY_A;
                state_d = StTxc;
            end
            StTxc: begin
                if (poll_ready(i_data)) begin
                    state_d = StTxw;
                end else begin
                    state_d   = StGap;
                    gap_cnt_d = GapInit;
                end
            end
            StTxw: begin
                o_en         = 1'b1;
                o_wr         = 1'b1;
                o_addr       = TX_DAT_A;
                o_data       = tx_byte_q;
                tx_pending_d = 1'b0;
                state_d      = StIdle;
            end
            StRxq: begin
                o_en    = 1'b1;
                o_addr  = RX_RDY_A;
                state_d = StRxc;
            end
            StRxc: begin
                if (poll_ready(i_data)) begin
                    state_d = StRxd;
                end else begin
                    state_d   = StGap;
                    gap_cnt_d = GapInit;
                end
            end
            StRxd: begin
                o_en    = 1'b1;
                o_addr  = RX_DAT_A;
                state_d = StRxl;
            end
            StRxl: begin
                rx_data_d  = i_data;
                rx_valid_d = 1'b1;
                state_d    = StIdle;
            end
            StGap: begin
                // A load of 0 or 1 leaves after this single GAP cycle.
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d = 8'd0;
                    state_d   = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (i_rst) begin
            o_en   = 1'b0;
            o_wr   = 1'b0;
            o_addr = 4'h0;
            o_data = 8'h00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            tx_pending_q <= 1'b0;
            tx_byte_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            gap_cnt_q    <= 8'd0;
            prio_rx_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_pending_q <= tx_pending_d;
            tx_byte_q    <= tx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            gap_cnt_q    <= gap_cnt_d;
            prio_rx_q    <= prio_rx_d;
        end
    end

    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;

endmodule

// File: tb/tb_usb_uart_master.sv
// Directed bench for usb_uart_master with a register-level device model and access log.
module tb_usb_uart_master;

    localparam int LogDepth = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] dev_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       en;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;

    int total = 0;
    int bad   = 0;

    // Device model state and access log (written only by the model process).
    int         cyc = 0;
    int         acc_cnt = 0;
    int         tx_rdy_reads = 0;
    logic       acc_wr   [LogDepth];
    logic [3:0] acc_addr [LogDepth];
    logic [7:0] acc_data [LogDepth];
    int         acc_cyc  [LogDepth];

    // Device configuration (written only by the stimulus process).
    int         tx_nr_until = 0;
    logic [7:0] rx_rdy_val = 8'h00;
    logic [7:0] rx_dat_val = 8'h00;

    always #5 clk = ~clk;

    usb_uart_master #(.POLL_GAP(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_tx_valid(tx_valid),
        .i_tx_data (tx_data),
        .o_tx_ready(tx_ready),
        .o_rx_valid(rx_valid),
        .o_rx_data (rx_data),
        .i_rx_ready(rx_ready),
        .o_en      (en),
        .o_wr      (wr),
        .o_addr    (addr),
        .o_data    (wdata),
        .i_data    (dev_data)
    );

    // Read data appears the cycle after the access; 8'hEE otherwise so late sampling is visible.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        dev_data <= 8'hEE;
        if (en) begin
            if (acc_cnt < LogDepth) begin
                acc_wr[acc_cnt]   <= wr;
                acc_addr[acc_cnt] <= addr;
                acc_data[acc_cnt] <= wdata;
                acc_cyc[acc_cnt]  <= cyc;
            end
            acc_cnt <= acc_cnt + 1;
            if (!wr) begin
                case (addr)
                    4'h0: begin
                        dev_data     <= (tx_rdy_reads >= tx_nr_until) ? 8'h01 : 8'h00;
                        tx_rdy_reads <= tx_rdy_reads + 1;
                    end
                    4'h2:    dev_data <= rx_rdy_val;
                    4'h3:    dev_data <= rx_dat_val;
                    default: dev_data <= 8'h00;
                endcase
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tx_valid   = 1'b1;
        tx_data    = 8'hAA;
        rx_ready   = 1'b0;
        rx_rdy_val = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (tx_ready !== 1'b0) begin
            bad++; $display("FAIL reset_hold_tx_ready got=%0b want=0", tx_ready);
        end
        total++;
        if (en !== 1'b0) begin
            bad++; $display("FAIL reset_hold_en got=%0b want=0", en);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        rst      = 1'b0;
        #1;
        total++;
        if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%0b want=0", en); end
        total++;
        if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%0b want=0", wr); end
        total++;
        if (addr !== 4'h0) begin bad++; $display("FAIL reset_addr got=%0h want=0", addr); end
        total++;
        if (wdata !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", wdata); end
        total++;
        if (tx_ready !== 1'b0) begin
            bad++; $display("FAIL reset_tx_ready got=%0b want=0", tx_ready);
        end
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rx_valid got=%0b want=0", rx_valid);
        end
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_rx_data got=%0h want=0", rx_data);
        end
    endtask

    task automatic test_rx_hold();
        int base, n_rdy, n_dat;
        rx_rdy_val = 8'hFF;
        rx_dat_val = 8'h33;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        do_reset();
        base = acc_cnt;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if (rx_valid !== 1'b1) begin
            bad++; $display("FAIL rx_hold_valid got=%0b want=1", rx_valid);
        end
        total++;
        if (rx_data !== 8'h33) begin
            bad++; $display("FAIL rx_hold_data got=%0h want=33", rx_data);
        end
        n_rdy = 0;
        n_dat = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (!acc_wr[k] && acc_addr[k] == 4'h2) n_rdy++;
            if (!acc_wr[k] && acc_addr[k] == 4'h3) n_dat++;
        end
        total++;
        if (n_rdy != 1) begin bad++; $display("FAIL rx_hold_rdy_reads got=%0d want=1", n_rdy); end
        total++;
        if (n_dat != 1) begin bad++; $display("FAIL rx_hold_dat_reads got=%0d want=1", n_dat); end
    endtask

    // Rx byte still held, so only tx is eligible.
    task automatic test_tx_basic();
        int base, t0, pulses;
        tx_nr_until = tx_rdy_reads;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h41;
        #1;
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL tx_basic_ready got=%0b want=1", tx_ready);
        end
        t0     = cyc;
        base   = acc_cnt;
        pulses = int'(tx_ready);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            #1;
            pulses += int'(tx_ready);
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL tx_basic_pulses got=%0d want=1", pulses); end
        total++;
        if (acc_cnt - base != 2) begin
            bad++; $display("FAIL tx_basic_count got=%0d want=2", acc_cnt - base);
        end
        total++;
        if (acc_wr[base] !== 1'b0 || acc_addr[base] !== 4'h0 || acc_cyc[base] != t0 + 1) begin
            bad++;
            $display("FAIL tx_basic_poll got wr=%0b addr=%0h cyc=%0d want wr=0 addr=0 cyc=%0d",
                     acc_wr[base], acc_addr[base], acc_cyc[base], t0 + 1);
        end
        total++;
        if (acc_wr[base+1] !== 1'b1 || acc_addr[base+1] !== 4'h1 || acc_data[base+1] !== 8'h41
            || acc_cyc[base+1] != t0 + 3) begin
            bad++;
            $display("FAIL tx_basic_write got wr=%0b addr=%0h data=%0h cyc=%0d want 1/1/41/%0d",
                     acc_wr[base+1], acc_addr[base+1], acc_data[base+1], acc_cyc[base+1], t0 + 3);
        end
    endtask

    task automatic test_back_to_back();
        int base, t0, idx, nw;
        tx_nr_until = tx_rdy_reads;
        @(negedge clk);
        base = acc_cnt;
        t0   = cyc;
        idx  = 0;
        for (int i = 0; i < 30; i++) begin
            tx_valid = (idx < 3);
            tx_data  = 8'hA0 + 8'(idx);
            #1;
            if (tx_ready && tx_valid) idx++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        nw = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (acc_wr[k]) begin
                total++;
                if (acc_data[k] !== 8'hA0 + 8'(nw) || acc_cyc[k] != t0 + 3 + 4 * nw) begin
                    bad++;
                    $display("FAIL b2b_write%0d got data=%0h cyc=%0d want data=%0h cyc=%0d", nw,
                             acc_data[k], acc_cyc[k], 8'hA0 + 8'(nw), t0 + 3 + 4 * nw);
                end
                nw++;
            end
        end
        total++;
        if (nw != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nw); end
    endtask

    // Three not-ready polls; each retry costs IDLE+TXQ+TXC+4 GAP = 7 cycles.
    task automatic test_gap();
        int base, t0, np, nw;
        tx_nr_until = tx_rdy_reads + 3;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        #1;
        t0   = cyc;
        base = acc_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        np = 0;
        nw = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (!acc_wr[k] && acc_addr[k] == 4'h0) begin
                total++;
                if (acc_cyc[k] != t0 + 1 + 7 * np) begin
                    bad++;
                    $display("FAIL gap_poll%0d got cyc=%0d want=%0d", np, acc_cyc[k],
                             t0 + 1 + 7 * np);
                end
                np++;
            end
            if (acc_wr[k]) begin
                total++;
                if (acc_data[k] !== 8'h5A || acc_cyc[k] != t0 + 24) begin
                    bad++;
                    $display("FAIL gap_write got data=%0h cyc=%0d want data=5a cyc=%0d",
                             acc_data[k], acc_cyc[k], t0 + 24);
                end
                nw++;
            end
        end
        total++;
        if (np != 4) begin bad++; $display("FAIL gap_polls got=%0d want=4", np); end
        total++;
        if (nw != 1) begin bad++; $display("FAIL gap_writes got=%0d want=1", nw); end
    endtask

    task automatic test_rx_consume();
        int base, n_dat;
        rx_dat_val = 8'h34;
        @(negedge clk);
        rx_ready = 1'b1;
        #1;
        total++;
        if (rx_data !== 8'h33) begin
            bad++; $display("FAIL consume_old_data got=%0h want=33", rx_data);
        end
        base = acc_cnt;
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        total++;
        if (rx_valid !== 1'b0) begin
            bad++; $display("FAIL consume_clear got=%0b want=0", rx_valid);
        end
        for (int i = 0; i < 20 && !rx_valid; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h34) begin
            bad++;
            $display("FAIL consume_next got valid=%0b data=%0h want valid=1 data=34",
                     rx_valid, rx_data);
        end
        repeat (10) @(negedge clk);
        n_dat = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (!acc_wr[k] && acc_addr[k] == 4'h3) n_dat++;
        end
        total++;
        if (n_dat != 1) begin bad++; $display("FAIL consume_dat_reads got=%0d want=1", n_dat); end
    endtask

    task automatic test_alternate();
        int base, idx, nw, n_err, guard;
        rx_rdy_val  = 8'h80;
        rx_dat_val  = 8'h5C;
        rx_ready    = 1'b1;
        tx_nr_until = tx_rdy_reads;
        tx_valid    = 1'b1;
        tx_data     = 8'h00;
        do_reset();
        base  = acc_cnt;
        idx   = 0;
        guard = 0;
        while ((acc_cnt - base < 64) && guard < 600) begin
            tx_valid = (idx < 16);
            tx_data  = 8'(idx);
            #1;
            if (tx_ready && tx_valid) idx++;
            @(negedge clk);
            guard++;
        end
        tx_valid = 1'b0;
        total++;
        if (acc_cnt - base < 64) begin
            bad++; $display("FAIL alt_timeout got=%0d want>=64 accesses", acc_cnt - base);
        end
        n_err = 0;
        for (int k = 0; k < 64 && base + k < acc_cnt; k++) begin
            if (acc_addr[base+k] !== 4'(k % 4)) n_err++;
        end
        total++;
        if (n_err != 0) begin bad++; $display("FAIL alt_order got=%0d bad_slots want=0", n_err); end
        nw    = 0;
        n_err = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (acc_wr[k]) begin
                if (acc_data[k] !== 8'(nw)) n_err++;
                nw++;
            end
        end
        total++;
        if (nw != 16 || n_err != 0) begin
            bad++; $display("FAIL alt_bytes got=%0d writes %0d wrong want=16 writes 0 wrong",
                            nw, n_err);
        end
    endtask

    task automatic test_reset_mid();
        int base, nw;
        rx_rdy_val  = 8'hFF;
        rx_dat_val  = 8'h55;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_nr_until = tx_rdy_reads;
        do_reset();
        for (int i = 0; i < 20 && !rx_valid; i++) @(negedge clk);
        #1;
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
            bad++; $display("FAIL mid_setup got valid=%0b data=%0h want 1/55", rx_valid, rx_data);
        end
        rx_rdy_val = 8'h00;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        #1;
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL mid_accept got=%0b want=1", tx_ready);
        end
        base = acc_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        #1;
        total++;
        if (en !== 1'b1 || addr !== 4'h0) begin
            bad++; $display("FAIL mid_txq got en=%0b addr=%0h want en=1 addr=0", en, addr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (en !== 1'b0 || wr !== 1'b0 || addr !== 4'h0 || wdata !== 8'h00 || tx_ready !== 1'b0
            || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_outputs got en=%0b wr=%0b addr=%0h data=%0h rdy=%0b rxv=%0b rxd=%0h",
                     en, wr, addr, wdata, tx_ready, rx_valid, rx_data);
        end
        repeat (30) @(negedge clk);
        nw = 0;
        for (int k = base; k < acc_cnt; k++) begin
            if (acc_wr[k]) nw++;
        end
        total++;
        if (nw != 0) begin bad++; $display("FAIL mid_no_write got=%0d want=0", nw); end
    endtask

    initial begin
        test_reset();
        test_rx_hold();
        test_tx_basic();
        test_back_to_back();
        test_gap();
        test_rx_consume();
        test_alternate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_uart_master.md
USB_UART_MASTER -- requirements
Module: usb_uart_master

Interface
REQ-001 Parameter POLL_GAP, default 4, idle cycles inserted after a not-ready poll before the next poll (0 allowed).
REQ-002 Parameter TX_RDY_A/TX_DAT_A/RX_RDY_A/RX_DAT_A, defaults 4'h0/4'h1/4'h2/4'h3, device register addresses.
REQ-003 Port i_clk  in  1  system clock (12MHz); the block SHALL use one clock.
REQ-004 Port i_rst  in  1  reset; the reset SHALL be synchronous and active-high.
REQ-005 Port i_tx_valid  in  1  client byte to send is offered.
REQ-006 Port i_tx_data  in  8  client byte to send.
REQ-007 Port o_tx_ready  out  1  client byte accepted this cycle.
REQ-008 Port o_rx_valid  out  1  received byte held for client.
REQ-009 Port o_rx_data  out  8  received byte.
REQ-010 Port i_rx_ready  in  1  client consumes o_rx_data this cycle.
REQ-011 Port o_en  out  1  device register access enable.
REQ-012 Port o_wr  out  1  access direction {0:read, 1:write}.
REQ-013 Port o_addr  out  4  device register address.
REQ-014 Port o_data  out  8  device write data.
REQ-015 Port i_data  in  8  device read data, valid the cycle after a read access.

Function
REQ-016 The block SHALL be the bus initiator for the USB UART register interface, turning tx/rx byte streams into polled register accesses.
REQ-017 FSM states SHALL be: IDLE, TXQ (read TX_RDY), TXC (check), TXW (write TX_DAT), RXQ (read RX_RDY), RXC (check), RXD (read RX_DAT), RXL (latch), GAP (back-off).
REQ-018 o_en SHALL be 1 only in TXQ, TXW, RXQ, RXD, one cycle each; o_wr=1 only in TXW; o_addr/o_data SHALL be 0 whenever o_en=0.
REQ-019 Read data SHALL be sampled from i_data exactly one cycle after the read access (in TXC, RXC, RXL).
REQ-020 A poll SHALL be ready iff i_data != 8'h00.
REQ-021 In IDLE, tx_pending=0 and i_tx_valid=1: o_tx_ready SHALL pulse for one cycle, i_tx_data SHALL be latched, tx_pending set.
REQ-022 In IDLE the block SHALL choose TXQ if tx_pending, RXQ if !o_rx_valid, alternating priority (last served loses) when both are eligible; otherwise it stays in IDLE.
REQ-023 TXC ready -> TXW writing the latched byte, then tx_pending cleared, -> IDLE; not ready -> GAP.
REQ-024 RXC ready -> RXD -> RXL; RXL SHALL load o_rx_data from i_data, set o_rx_valid, -> IDLE; not ready -> GAP.
REQ-025 o_rx_valid SHALL clear on the cycle after o_rx_valid&&i_rx_ready; no RX_DAT read SHALL be issued while o_rx_valid=1 (no byte loss).
REQ-026 GAP SHALL count POLL_GAP cycles via a down-counter, then -> IDLE; POLL_GAP=0 SHALL pass through GAP in one cycle.
REQ-027 Tx throughput with device always ready SHALL be one byte per 4 cycles (IDLE,TXQ,TXC,TXW) when rx is not eligible.
REQ-028 i_tx_valid dropping after acceptance SHALL have no effect; the latched byte is always written.

Reset
REQ-029 When i_rst=1 at a clock edge, state SHALL become IDLE, tx_pending=0, o_tx_ready=0, o_rx_valid=0, o_rx_data=0, o_en=0, o_wr=0, o_addr=0, o_data=0, gap counter=0, priority=tx-first.
REQ-030 Reset mid-transaction SHALL abandon it: a latched tx byte and a held rx byte are discarded, and no further bus access occurs in the reset cycle.

Structure
REQ-031 Register address constants (TX_RDY, TX_DAT, RX_RDY, RX_DAT) and FSM state encodings SHALL live in a shared header included by both the device and this block.
REQ-032 The block SHALL be flat; no sub-module is needed.

Verification
REQ-033 Device model ready always; offer tx 8'h41 -> accesses rd 0, wr 1 data 8'h41, o_tx_ready one pulse, 4 cycles.
REQ-034 TX_RDY returns 0 three times, POLL_GAP=4 -> three polls spaced by GAP, then write of 8'h5A; no write earlier.
REQ-035 RX_RDY=FF, RX_DAT=8'h33, i_rx_ready=0 for 20 cycles -> o_rx_valid=1, o_rx_data=33, no further RX_RDY/RX_DAT reads until consumed.
REQ-036 tx and rx both eligible continuously -> accesses alternate TX/RX sequences; bytes 00..0F each sent exactly once, in order.
REQ-037 Assert i_rst in TXC with byte 8'h77 latched -> next cycle all outputs 0; 8'h77 never written.
